// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types for the unified fetch/data memory arbiter.
// Imported by mem_arbiter and mem_arb_picker.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DONE
  } arb_state_t;

  typedef enum logic {
    OWN_I,
    OWN_D
  } arb_owner_t;

  function automatic int be_width(input int dw);
    return dw / 8;
  endfunction

  localparam int BE_WIDTH = be_width(32);

endpackage

// File: rtl/mem_arb_picker.sv
// mem_arb_picker: fetch/data winner selection for mem_arbiter.
// ARB_ROUND_ROBIN_EN adds a round-robin pointer; otherwise data beats fetch.
module mem_arb_picker
  import mem_arb_pkg::*;
(
`ifdef ARB_ROUND_ROBIN_EN
  input  logic       clk,
  input  logic       rst,
  input  logic       grant_i,
`endif
  input  logic       ireq_i,
  input  logic       dreq_i,
  output logic       any_o,
  output arb_owner_t win_o
);

  assign any_o = ireq_i | dreq_i;

`ifdef ARB_ROUND_ROBIN_EN
  // ptr_q names the requester that wins the next tie
  arb_owner_t ptr_q;
  arb_owner_t ptr_d;

  always_comb begin
    win_o = OWN_I;
    unique case (1'b1)
      ireq_i && dreq_i:  win_o = ptr_q;
      dreq_i && !ireq_i: win_o = OWN_D;
      default:           win_o = OWN_I;
    endcase
  end

  assign ptr_d = (win_o == OWN_I) ? OWN_D : OWN_I;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q <= OWN_I;
    end else if (grant_i && any_o) begin
      ptr_q <= ptr_d;
    end
  end
`else
  assign win_o = dreq_i ? OWN_D : OWN_I;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: one outstanding transaction on a memory port shared by fetch and data.
// Define ARB_ROUND_ROBIN_EN for round-robin ties; default is data-over-fetch priority.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    IReq_i,
  input  logic [ADDR_WIDTH-1:0]   IAddr_i,
  output logic [DATA_WIDTH-1:0]   IRdata_o,
  output logic                    IValid_o,
  output logic                    IStall_o,
  input  logic                    DReq_i,
  input  logic                    DWe_i,
  input  logic [ADDR_WIDTH-1:0]   DAddr_i,
  input  logic [DATA_WIDTH-1:0]   DWdata_i,
  input  logic [DATA_WIDTH/8-1:0] DBe_i,
  output logic [DATA_WIDTH-1:0]   DRdata_o,
  output logic                    DValid_o,
  output logic                    DStall_o,
  output logic                    MemReq_o,
  output logic                    MemWe_o,
  output logic [ADDR_WIDTH-1:0]   MemAddr_o,
  output logic [DATA_WIDTH-1:0]   MemWdata_o,
  output logic [DATA_WIDTH/8-1:0] MemBe_o,
  input  logic                    MemGnt_i,
  input  logic                    MemRvalid_i,
  input  logic [DATA_WIDTH-1:0]   MemRdata_i,
  output logic                    Timeout_o
);

  localparam int BW = be_width(DATA_WIDTH);
  localparam int CW = (TIMEOUT_CYCLES < 2) ? 1
                    : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  arb_state_t            state_q, state_d;
  arb_owner_t            owner_q, owner_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [BW-1:0]         be_q, be_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  to_q, to_d;
  logic [DATA_WIDTH-1:0] ird_q, ird_d;
  logic [DATA_WIDTH-1:0] drd_q, drd_d;

  logic                  any;
  arb_owner_t            win;
  logic                  wd_hit;
  logic                  fin;
  logic [DATA_WIDTH-1:0] fin_data;

  mem_arb_picker u_pick (
`ifdef ARB_ROUND_ROBIN_EN
    .clk     (clk),
    .rst     (rst),
    .grant_i (state_q == IDLE),
`endif
    .ireq_i  (IReq_i),
    .dreq_i  (DReq_i),
    .any_o   (any),
    .win_o   (win)
  );

  assign wd_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST);

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    be_d     = be_q;
    cnt_d    = cnt_q;
    to_d     = to_q;
    ird_d    = ird_q;
    drd_d    = drd_q;
    fin      = 1'b0;
    fin_data = MemRdata_i;
    unique case (state_q)
      IDLE: begin
        if (any) begin
          owner_d = win;
          cnt_d   = '0;
          state_d = REQ;
          if (win == OWN_D) begin
            we_d    = DWe_i;
            addr_d  = DAddr_i;
            wdata_d = DWdata_i;
            be_d    = DBe_i;
          end else begin
            we_d    = 1'b0;
            addr_d  = IAddr_i;
            wdata_d = '0;
            be_d    = '1;
          end
        end
      end
      REQ: begin
        cnt_d = cnt_q + 1'b1;
        if (MemGnt_i && MemRvalid_i) begin
          fin = 1'b1;
        end else if (wd_hit) begin
          fin      = 1'b1;
          fin_data = '0;
          to_d     = 1'b1;
        end else if (MemGnt_i) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (MemRvalid_i) begin
          fin = 1'b1;
        end else if (wd_hit) begin
          fin      = 1'b1;
          fin_data = '0;
          to_d     = 1'b1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // a write completion returns zero data to the owner
    if (fin) begin
      state_d = DONE;
      if (owner_q == OWN_D) begin
        drd_d = we_q ? '0 : fin_data;
      end else begin
        ird_d = fin_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      owner_q <= OWN_I;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      cnt_q   <= '0;
      to_q    <= 1'b0;
      ird_q   <= '0;
      drd_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      cnt_q   <= cnt_d;
      to_q    <= to_d;
      ird_q   <= ird_d;
      drd_q   <= drd_d;
    end
  end

  // a flushed fetch (dropped or redirected) gets no response pulse
  assign IValid_o = (state_q == DONE) && (owner_q == OWN_I)
                 && IReq_i && (IAddr_i == addr_q);
  assign DValid_o = (state_q == DONE) && (owner_q == OWN_D);
  assign IStall_o = IReq_i & ~IValid_o;
  assign DStall_o = DReq_i & ~DValid_o;

  assign IRdata_o   = ird_q;
  assign DRdata_o   = drd_q;
  assign MemReq_o   = (state_q == REQ);
  assign MemWe_o    = we_q;
  assign MemAddr_o  = addr_q;
  assign MemWdata_o = wdata_q;
  assign MemBe_o    = be_q;
  assign Timeout_o  = to_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed stimulus for mem_arbiter with a bench-side memory
// and a transaction-level model compared on every falling clock edge.
module tb_mem_arbiter;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        IReq_i = 1'b0;
  logic [31:0] IAddr_i = '0;
  logic [31:0] IRdata_o;
  logic        IValid_o, IStall_o;
  logic        DReq_i = 1'b0;
  logic        DWe_i = 1'b0;
  logic [31:0] DAddr_i = '0;
  logic [31:0] DWdata_i = '0;
  logic [3:0]  DBe_i = '0;
  logic [31:0] DRdata_o;
  logic        DValid_o, DStall_o;
  logic        MemReq_o, MemWe_o;
  logic [31:0] MemAddr_o, MemWdata_o;
  logic [3:0]  MemBe_o;
  logic        MemGnt_i, MemRvalid_i;
  logic [31:0] MemRdata_i;
  logic        Timeout_o;

  always #5 clk = ~clk;

  mem_arbiter #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .IReq_i(IReq_i), .IAddr_i(IAddr_i), .IRdata_o(IRdata_o),
    .IValid_o(IValid_o), .IStall_o(IStall_o),
    .DReq_i(DReq_i), .DWe_i(DWe_i), .DAddr_i(DAddr_i),
    .DWdata_i(DWdata_i), .DBe_i(DBe_i), .DRdata_o(DRdata_o),
    .DValid_o(DValid_o), .DStall_o(DStall_o),
    .MemReq_o(MemReq_o), .MemWe_o(MemWe_o), .MemAddr_o(MemAddr_o),
    .MemWdata_o(MemWdata_o), .MemBe_o(MemBe_o),
    .MemGnt_i(MemGnt_i), .MemRvalid_i(MemRvalid_i),
    .MemRdata_i(MemRdata_i), .Timeout_o(Timeout_o)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // bench memory: unwritten words read back as ~address
  logic [31:0] mem [logic [31:0]];
  int gnt_delay = 0;
  int rv_lat = 1;
  bit mem_dead = 0;
  bit force_rv = 0;

  function automatic logic [31:0] mem_access(input logic we,
      input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be);
    logic [31:0] w;
    w = mem.exists(a) ? mem[a] : (we ? 32'h0 : ~a);
    if (!we) return w;
    for (int b = 0; b < 4; b++)
      if (be[b]) w[8*b +: 8] = wd[8*b +: 8];
    mem[a] = w;
    return 32'h0;
  endfunction

  initial begin
    int gc;
    int rc;
    bit pend;
    logic [31:0] rd;
    gc = 0; rc = 0; pend = 0; rd = '0;
    MemGnt_i = 0; MemRvalid_i = 0; MemRdata_i = '0;
    forever begin
      @(posedge clk); #2;
      MemGnt_i = 0;
      MemRvalid_i = 0;
      if (!rst) begin
        pend = 0; gc = 0;
      end else if (pend) begin
        if (rc == 0) begin
          MemRvalid_i = 1; MemRdata_i = rd; pend = 0;
        end else rc--;
      end else if (MemReq_o && !mem_dead) begin
        if (gc < gnt_delay) gc++;
        else begin
          gc = 0;
          MemGnt_i = 1;
          rd = mem_access(MemWe_o, MemAddr_o, MemWdata_o, MemBe_o);
          if (rv_lat == 0) begin
            MemRvalid_i = 1; MemRdata_i = rd;
          end else begin
            pend = 1; rc = rv_lat - 1;
          end
        end
      end
      if (force_rv) begin
        MemRvalid_i = 1; MemRdata_i = 32'hBAD0BAD0;
      end
    end
  end

  // transaction-level model: one request in flight, response the cycle after it ends
  bit          m_busy, m_gnt, m_due, m_own, m_last, m_to, m_we;
  int          m_cnt;
  logic [31:0] m_addr, m_wdata, m_ird, m_drd;
  logic [3:0]  m_be;

  initial begin
    bit ev_i, ev_d;
    forever begin
      @(negedge clk);
      if (!rst) begin
        m_busy = 0; m_gnt = 0; m_due = 0; m_to = 0; m_last = 1;
        m_ird = '0; m_drd = '0; m_cnt = 0;
        chk("rst_memreq", MemReq_o, 0);
        chk("rst_ivalid", IValid_o, 0);
        chk("rst_dvalid", DValid_o, 0);
        chk("rst_timeout", Timeout_o, 0);
      end else begin
        chk("cyc_memreq", MemReq_o, m_busy && !m_gnt);
        if (m_busy && !m_gnt) begin
          chk("cyc_memaddr", MemAddr_o, m_addr);
          chk("cyc_memwe", MemWe_o, m_we);
          chk("cyc_membe", MemBe_o, m_be);
          if (m_we) chk("cyc_memwdata", MemWdata_o, m_wdata);
        end
        ev_i = m_due && !m_own && IReq_i && (IAddr_i == m_addr);
        ev_d = m_due && m_own;
        chk("cyc_ivalid", IValid_o, ev_i);
        chk("cyc_dvalid", DValid_o, ev_d);
        chk("cyc_istall", IStall_o, IReq_i && !ev_i);
        chk("cyc_dstall", DStall_o, DReq_i && !ev_d);
        chk("cyc_irdata", IRdata_o, m_ird);
        chk("cyc_drdata", DRdata_o, m_drd);
        chk("cyc_timeout", Timeout_o, m_to);
        if (m_due) begin
          m_due = 0;
        end else if (!m_busy) begin
          if (IReq_i || DReq_i) begin
`ifdef ARB_ROUND_ROBIN_EN
            m_own = (IReq_i && DReq_i) ? !m_last : DReq_i;
`else
            m_own = DReq_i;
`endif
            m_last = m_own;
            m_we = m_own ? DWe_i : 1'b0;
            m_addr = m_own ? DAddr_i : IAddr_i;
            m_wdata = DWdata_i;
            m_be = m_own ? DBe_i : 4'hF;
            m_busy = 1; m_gnt = 0; m_cnt = 0;
          end
        end else begin
          logic [31:0] v;
          bit done;
          done = 0; v = '0;
          m_cnt++;
          if (MemRvalid_i && (m_gnt || MemGnt_i)) begin
            done = 1; v = m_we ? 32'h0 : MemRdata_i;
          end else if (m_cnt == TO) begin
            done = 1; m_to = 1;
          end else if (MemGnt_i) m_gnt = 1;
          if (done) begin
            m_busy = 0; m_gnt = 0; m_due = 1;
            if (m_own) m_drd = v; else m_ird = v;
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

  task automatic apply_reset();
    rst = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1;
  endtask

  task automatic fetch_check(input logic [31:0] a, input logic [31:0] d,
                             input string nm);
    IReq_i = 1; IAddr_i = a;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk({nm, "_istall"}, IStall_o, c < 3);
      chk({nm, "_ivalid"}, IValid_o, c == 3);
      if (c == 3) chk({nm, "_irdata"}, IRdata_o, d);
      @(posedge clk); #1;
    end
    IReq_i = 0;
  endtask

`ifdef ARB_ROUND_ROBIN_EN
  localparam logic [2:0] T3_ORDER = 3'b010;
`else
  localparam logic [2:0] T3_ORDER = 3'b111;
`endif

  initial begin
    int npulse, vcyc, n;
    logic [2:0] ord;
    bit seen_old, got;
    mem[32'h100] = 32'hDEADBEEF;
    @(posedge clk); #1;
    apply_reset();
    repeat (2) begin @(posedge clk); #1; end

    // 1: fetch only, minimum latency
    fetch_check(32'h100, 32'hDEADBEEF, "t1");
    repeat (2) begin @(posedge clk); #1; end

    // 2: data write held through three refused grants
    gnt_delay = 3;
    DReq_i = 1; DWe_i = 1; DAddr_i = 32'h2000;
    DWdata_i = 32'h12345678; DBe_i = 4'b0011;
    npulse = 0; vcyc = -1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (c >= 1 && c <= 4) begin
        chk("t2_memreq", MemReq_o, 1);
        chk("t2_memaddr", MemAddr_o, 32'h2000);
        chk("t2_memwe", MemWe_o, 1);
        chk("t2_membe", MemBe_o, 4'b0011);
      end
      if (DValid_o) begin npulse++; vcyc = c; end
      @(posedge clk); #1;
      if (npulse > 0) DReq_i = 0;
    end
    DWe_i = 0; gnt_delay = 0;
    chk("t2_pulses", npulse, 1);
    chk("t2_vcycle", vcyc, 6);
    chk("t2_memword", mem[32'h2000], 32'h00005678);

    // 3: simultaneous requests, three rounds right after reset
    apply_reset();
    IReq_i = 1; IAddr_i = 32'h300;
    DReq_i = 1; DWe_i = 0; DAddr_i = 32'h400; DBe_i = 4'hF;
    ord = '0; n = 0;
    for (int c = 0; c < 30 && n < 3; c++) begin
      @(negedge clk);
      if (IValid_o) begin ord = {ord[1:0], 1'b0}; n++; end
      if (DValid_o) begin ord = {ord[1:0], 1'b1}; n++; end
      @(posedge clk); #1;
    end
    IReq_i = 0; DReq_i = 0;
    chk("t3_rounds", n, 3);
    chk("t3_order", ord, T3_ORDER);
    repeat (2) begin @(posedge clk); #1; end

    // 4: fetch redirected while waiting on memory
    rv_lat = 3;
    IReq_i = 1; IAddr_i = 32'h100;
    seen_old = 0; got = 0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      if (c <= 5 && IValid_o) seen_old = 1;
      if (c == 7) begin
        chk("t4_memreq", MemReq_o, 1);
        chk("t4_memaddr", MemAddr_o, 32'h200);
      end
      if (c > 5 && IValid_o) begin
        got = 1;
        chk("t4_irdata", IRdata_o, 32'hFFFFFDFF);
      end
      @(posedge clk); #1;
      if (c == 1) IAddr_i = 32'h200;
    end
    IReq_i = 0; rv_lat = 1;
    chk("t4_no_stale", seen_old, 0);
    chk("t4_redirect_done", got, 1);
    repeat (2) begin @(posedge clk); #1; end

    // 5: memory never answers
    mem_dead = 1;
    DReq_i = 1; DWe_i = 0; DAddr_i = 32'h500;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (c == 8) begin
        chk("t5_flag_early", Timeout_o, 0);
        chk("t5_memreq_held", MemReq_o, 1);
      end
      if (c == 9) begin
        chk("t5_flag", Timeout_o, 1);
        chk("t5_dvalid", DValid_o, 1);
        chk("t5_drdata", DRdata_o, 32'h0);
      end
      if (c == 10) begin
        chk("t5_idle_memreq", MemReq_o, 0);
        chk("t5_single_pulse", DValid_o, 0);
      end
      @(posedge clk); #1;
      if (c == 9) DReq_i = 0;
    end
    mem_dead = 0;

    // 6: reset lands in WAIT, then a stray rvalid
    rv_lat = 3;
    IReq_i = 1; IAddr_i = 32'h600;
    repeat (2) begin @(posedge clk); #1; end
    rst = 0; IReq_i = 0;
    #1;
    chk("t6_memreq", MemReq_o, 0);
    chk("t6_flag_clear", Timeout_o, 0);
    chk("t6_istall", IStall_o, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1; force_rv = 1;
    @(posedge clk); #1 force_rv = 0;
    npulse = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (IValid_o || DValid_o || MemReq_o) npulse++;
      @(posedge clk); #1;
    end
    chk("t6_late_rvalid", npulse, 0);
    rv_lat = 1;
    fetch_check(32'h100, 32'hDEADBEEF, "t6_after");
    repeat (2) begin @(posedge clk); #1; end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
